btn_enc_8_3: RTL
================

// Module: btn_enc_8_3
// PURPOSE
//  Front-end encoder for the stopwatch's 8 active-low pushbuttons (start/stop/lap/clear/mode...).
//  Synchronises and debounces the raw pins, then priority-encodes each new press to a 3-bit code.
//  Press events are delivered to the control FSM over a valid/ready handshake.
//  Inverse of the display path's 3->8 active-low one-hot decode: active-low 8 lines in, 3-bit index out.
// PARAMETERS
//  SYNC_STAGES      2          synchroniser depth per button bit (>=2)
//  DEBOUNCE_CYCLES  1_000_000  cycles synced vector must be stable before acceptance (10 ms @ 100 MHz; >=2)
//  CNT_W            $clog2(DEBOUNCE_CYCLES)  localparam, debounce counter width
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous active-low reset
//  btn_n      in   8  raw button pins, active-low, asynchronous to clk
//  pressed_o  out  8  debounced button levels, active-high (1 = held)
//  code_o     out  3  index of reported press; valid only while valid_o=1
//  multi_o    out  1  >1 button newly pressed in the reported event; qualified by valid_o
//  valid_o    out  1  press event pending
//  ready_i    in   1  consumer accepts event when valid_o && ready_i on a rising clk edge
//  overrun_o  out  1  one-cycle pulse: new event dropped because one was already pending
// BEHAVIOUR
//  Reset (async assert, sync release): sync flops = 1 (released); cand = 8'hFF; cnt = 0;
//   pressed_o = 0; code_o = 0; multi_o = 0; valid_o = 0; overrun_o = 0; FSM = S_IDLE.
//  Synchroniser: SYNC_STAGES flops per bit on btn_n; output s (active-low).
//  Debounce, one shared counter for the whole vector:
//   - s != cand: cand <= s, cnt <= 0.
//   - s == cand && cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//   - s == cand && cnt == DEBOUNCE_CYCLES-1: pressed_o <= ~cand; cnt holds (saturates).
//   - Any bit toggling restarts the window for all bits.
//  Event detect: new = ~cand & ~pressed_o, evaluated on the cycle pressed_o updates.
//   Event exists iff new != 0. Releases generate no event.
//   code = highest set index of new; multi = popcount(new) > 1.
//  FSM (typedef enum, 2 states):
//   S_IDLE: valid_o = 0. On event: load code_o/multi_o, go to S_PEND.
//   S_PEND: valid_o = 1; code_o/multi_o stable.
//     ready_i=1, no event: go to S_IDLE.
//     ready_i=1, event same edge: load new event, stay in S_PEND.
//       valid_o stays 1; no overrun.
//     ready_i=0, event: event dropped, held event kept, overrun_o = 1 for one cycle.
//  Latency: raw edge to valid_o = SYNC_STAGES + DEBOUNCE_CYCLES + 2 clk edges.
//   Edge 1 is the first edge sampling the new raw level. Handshake adds no bubble.
//  Counter never wraps (saturates). All outputs are registered.
//  Mid-operation reset discards any pending event.
//   After release, a button still held is reported again as a fresh press once debounced.
// STRUCTURE
//  Package btn_pkg: BTN_W=8, CODE_W=3, typedef enum logic {S_IDLE,S_PEND} btn_state_t,
//   function prio_enc8 (8 -> 3, highest index wins).
//  Sub-module btn_debounce: synchroniser + shared counter.
//   Ports clk, rst_n, btn_n, pressed_o, upd_o, where upd_o is a one-cycle strobe when pressed_o is written.
//  Top: event detect, encoder, handshake FSM.
// TESTING  (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
//  1 Reset with btn_n=8'hFF -> pressed_o=0, valid_o=0, code_o=0, overrun_o=0.
//    Assert rst_n=0 mid-run -> outputs clear without a clk edge.
//  2 btn_n=8'hF7 held, ready_i=1 -> valid_o high exactly 1 cycle at edge 8.
//    code_o=3, multi_o=0, pressed_o=8'h08.
//  3 bit5 toggled every 2 cycles for 20 cycles, then 8'hFF -> no valid_o, pressed_o stays 0.
//  4 btn_n=8'hF7 -> 8'h5F same cycle (bits 5,7 low) -> code_o=7, multi_o=1, pressed_o=8'hA0.
//  5 ready_i=0; press bit1 -> valid_o, code_o=1.
//    Release, then press bit2 -> overrun_o 1-cycle pulse; code_o stays 1.
//    ready_i=1 -> valid_o drops next edge.
//  6 valid_o=1, ready_i=1 on the edge a new press of bit6 is accepted.
//    -> valid_o stays 1, code_o=6, overrun_o=0.

Source files
------------

// File: rtl/btn_enc_8_3_pkg.sv
// Shared widths, handshake FSM states and the 8->3 priority encoder for the button front end.
package btn_pkg;

  localparam int BTN_W  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {S_IDLE, S_PEND} btn_state_t;

  // Highest set index wins; an all-zero vector encodes to 0.
  function automatic logic [CODE_W-1:0] prio_enc8(input logic [BTN_W-1:0] v);
    prio_enc8 = '0;
    for (int i = 0; i < BTN_W; i++) begin
      if (v[i]) prio_enc8 = CODE_W'(i);
    end
  endfunction

endpackage

// File: rtl/btn_enc_8_3_if.sv
// Press-event handshake between the button encoder (master) and the control FSM (slave).
interface btn_enc_8_3_if;
  import btn_pkg::*;

  logic [CODE_W-1:0] code_o;
  logic              multi_o;
  logic              valid_o;
  logic              ready_i;
  logic              overrun_o;

  modport master (output code_o, output multi_o, output valid_o, output overrun_o, input ready_i);
  modport slave  (input code_o, input multi_o, input valid_o, input overrun_o, output ready_i);

endinterface

// File: rtl/btn_enc_8_3_debounce.sv
// Synchronise raw active-low buttons and accept the vector once stable for DEBOUNCE_CYCLES.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges to pressed_o; upd_o strobes when pressed_o changes.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BTN_W-1:0] btn_n,
  output logic [BTN_W-1:0] pressed_o,
  output logic             upd_o
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][BTN_W-1:0] r_sync;
  logic [BTN_W-1:0]                  r_cand;
  logic [CNT_W-1:0]                  r_cnt;
  logic [BTN_W-1:0]                  w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '1;
      r_cand    <= '1;
      r_cnt     <= '0;
      pressed_o <= '0;
      upd_o     <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_n};
      upd_o  <= 1'b0;
      // One counter for the whole vector: any bit moving restarts every bit's window.
      if (w_s != r_cand) begin
        r_cand <= w_s;
        r_cnt  <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        pressed_o <= ~r_cand;
        upd_o     <= (pressed_o != ~r_cand);
      end
    end
  end

endmodule

// File: rtl/btn_enc_8_3.sv
// Debounced 8-button press encoder delivering {code, multi} events over valid/ready.
// Raw edge to valid_o is SYNC_STAGES+DEBOUNCE_CYCLES+2 edges; a pending event blocks new ones (overrun pulse).
module btn_enc_8_3
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BTN_W-1:0] btn_n,
  output logic [BTN_W-1:0] pressed_o,
  btn_enc_8_3_if.master    evt
);

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  logic [BTN_W-1:0]  w_pressed;
  logic              w_upd;
  logic [BTN_W-1:0]  r_prev;
  logic [BTN_W-1:0]  w_new;
  logic              w_evt;
  logic [CODE_W-1:0] w_enc;
  logic              w_multi;

  btn_state_t        r_state, w_state_nxt;
  logic [CODE_W-1:0] r_code, w_code_nxt;
  logic              r_multi, w_multi_nxt;
  logic              r_ovr, w_ovr_nxt;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  btn_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (w_rst_n),
    .btn_n     (btn_n),
    .pressed_o (w_pressed),
    .upd_o     (w_upd)
  );

  assign pressed_o = w_pressed;

  // r_prev lags pressed_o by one edge, so on the upd strobe it still holds the pre-update levels.
  assign w_new   = w_upd ? (w_pressed & ~r_prev) : '0;
  assign w_evt   = |w_new;
  assign w_enc   = prio_enc8(w_new);
  assign w_multi = |(w_new & (w_new - BTN_W'(1)));

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
      r_code  <= '0;
      r_multi <= 1'b0;
      r_ovr   <= 1'b0;
      r_prev  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_multi <= w_multi_nxt;
      r_ovr   <= w_ovr_nxt;
      r_prev  <= w_pressed;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_multi_nxt = r_multi;
    w_ovr_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_evt) begin
          w_state_nxt = S_PEND;
          w_code_nxt  = w_enc;
          w_multi_nxt = w_multi;
        end
      end
      S_PEND: begin
        if (evt.ready_i) begin
          if (w_evt) begin
            w_code_nxt  = w_enc;
            w_multi_nxt = w_multi;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_evt) begin
          w_ovr_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign evt.valid_o   = (r_state == S_PEND);
  assign evt.code_o    = r_code;
  assign evt.multi_o   = r_multi;
  assign evt.overrun_o = r_ovr;

endmodule
